// File: rtl/cache_arb_pkg.sv
// Shared types and widths for the I/D cache to main-memory arbiter.
package cache_arb_pkg;
    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;

    typedef enum logic [1:0] {ARB_IDLE, ARB_GNT_I, ARB_GNT_D} arb_state_t;
    typedef enum logic {REQ_I, REQ_D} arb_req_t;
endpackage

// File: rtl/cache_mem_arbiter_rr_arb2.sv
// Two-way round-robin pick: on contention the requester that was not served last wins.
module rr_arb2
    import cache_arb_pkg::*;
(
    input  logic     req_i,
    input  logic     req_d,
    input  arb_req_t last_grant,
    output logic     pick_valid,
    output arb_req_t pick
);
    always_comb begin
        pick_valid = req_i | req_d;
        pick       = REQ_I;
        if (req_i && req_d) begin
            pick = (last_grant == REQ_I) ? REQ_D : REQ_I;
        end else if (req_d) begin
            pick = REQ_D;
        end
    end
endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates one line-wide memory port between the I-cache and D-cache, routing the
// completion pulse and read line back to the granted cache only.
module cache_mem_arbiter #(
    parameter int ADDR_W = cache_arb_pkg::ADDR_W,
    parameter int LINE_W = cache_arb_pkg::LINE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_address,
    input  logic [LINE_W-1:0] i_wdata,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp,
    output logic              error
);
    import cache_arb_pkg::*;

    // Handshake: a cache raises read or write (never both) with address/wdata stable and holds
    // them until its single-cycle resp; resp (and rdata) pass through combinationally from
    // mem_resp while that cache is granted. At least one idle cycle separates transactions.

    arb_state_t state, state_nxt;
    arb_req_t   last_grant, last_nxt;
    logic       op_write, op_write_nxt;
    logic       error_nxt;
    logic       pick_valid;
    arb_req_t   pick;

    rr_arb2 u_pick (
        .req_i      (i_read | i_write),
        .req_d      (d_read | d_write),
        .last_grant (last_grant),
        .pick_valid (pick_valid),
        .pick       (pick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ARB_IDLE;
            last_grant <= REQ_I;
            op_write   <= 1'b0;
            error      <= 1'b0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_nxt;
            op_write   <= op_write_nxt;
            error      <= error_nxt;
        end
    end

    // The operation is latched at grant so a requester dropping early cannot abort the transfer.
    always_comb begin
        state_nxt    = state;
        last_nxt     = last_grant;
        op_write_nxt = op_write;
        error_nxt    = error;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_address  = '0;
        mem_wdata    = '0;
        i_resp       = 1'b0;
        i_rdata      = '0;
        d_resp       = 1'b0;
        d_rdata      = '0;
        case (state)
            ARB_IDLE: begin
                if (mem_resp) begin
                    error_nxt = 1'b1;
                end
                if (pick_valid) begin
                    if (pick == REQ_I) begin
                        state_nxt    = ARB_GNT_I;
                        op_write_nxt = i_write;
                        if (i_read && i_write) error_nxt = 1'b1;
                    end else begin
                        state_nxt    = ARB_GNT_D;
                        op_write_nxt = d_write;
                        if (d_read && d_write) error_nxt = 1'b1;
                    end
                end
            end
            ARB_GNT_I: begin
                mem_read    = ~op_write;
                mem_write   = op_write;
                mem_address = i_address;
                mem_wdata   = i_wdata;
                if (!(i_read || i_write)) error_nxt = 1'b1;
                if (mem_resp) begin
                    i_resp    = 1'b1;
                    i_rdata   = mem_rdata;
                    last_nxt  = REQ_I;
                    state_nxt = ARB_IDLE;
                end
            end
            ARB_GNT_D: begin
                mem_read    = ~op_write;
                mem_write   = op_write;
                mem_address = d_address;
                mem_wdata   = d_wdata;
                if (!(d_read || d_write)) error_nxt = 1'b1;
                if (mem_resp) begin
                    d_resp    = 1'b1;
                    d_rdata   = mem_rdata;
                    last_nxt  = REQ_D;
                    state_nxt = ARB_IDLE;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed scenarios plus randomized two-requester traffic checked against a transaction model.
module tb_cache_mem_arbiter;
    logic         clk = 1'b0;
    logic         rst;
    logic         i_read, i_write, d_read, d_write;
    logic [31:0]  i_address, d_address, mem_address;
    logic [255:0] i_wdata, d_wdata, i_rdata, d_rdata, mem_wdata, mem_rdata;
    logic         i_resp, d_resp, mem_read, mem_write, mem_resp, error;

    int n_checks = 0;
    int n_fail   = 0;

    logic mem_auto = 1'b0;
    logic model_on = 1'b0;

    // Transaction-level reference: who owns the memory port, who was served last,
    // and what the owner asked for when it was picked.
    int           m_owner = 0;  // 0 none, 1 I, 2 D
    int           m_last  = 1;
    logic         m_write;
    logic [31:0]  m_addr;
    logic [255:0] m_wdata;

    cache_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_write(i_write), .i_address(i_address), .i_wdata(i_wdata),
        .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .error(error)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        m_owner = 0;
        m_last  = 1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic set_req(input int who, input logic rd, input logic wr,
                           input logic [31:0] a, input logic [255:0] w);
        if (who == 0) begin
            i_read = rd; i_write = wr; i_address = a; i_wdata = w;
        end else begin
            d_read = rd; d_write = wr; d_address = a; d_wdata = w;
        end
    endtask

    task automatic pulse_resp(input logic [255:0] data);
        @(posedge clk); #1;
        mem_resp  = 1'b1;
        mem_rdata = data;
    endtask

    task automatic end_resp();
        @(posedge clk); #1;
        mem_resp  = 1'b0;
        mem_rdata = '0;
    endtask

    task automatic serve_one(input string tag, input logic [31:0] exp_addr);
        int t = 0;
        logic seen = 1'b0;
        while (!seen && t < 10) begin
            @(negedge clk);
            seen = mem_read | mem_write;
            t++;
        end
        if (!seen) check({tag, "_timeout"}, 0, 1);
        check({tag, "_addr"}, mem_address, exp_addr);
        pulse_resp(rand_line());
        end_resp();
    endtask

    task automatic run_req(input int who, input int count);
        for (int n = 0; n < count; n++) begin
            int idle = $urandom_range(0, 2);
            int t = 0;
            logic got = 1'b0;
            logic wr = $urandom_range(0, 1) == 1;
            if (idle > 0) begin
                set_req(who, 1'b0, 1'b0, '0, '0);
                repeat (idle) @(posedge clk);
                #1;
            end
            set_req(who, !wr, wr, {$urandom_range(0, 32'h07FF_FFFF), 5'b0}, rand_line());
            while (!got && t < 100) begin
                @(negedge clk);
                got = (who == 0) ? i_resp : d_resp;
                t++;
            end
            if (!got) check(who == 0 ? "rnd_i_timeout" : "rnd_d_timeout", 0, 1);
            @(posedge clk); #1;
        end
        set_req(who, 1'b0, 1'b0, '0, '0);
    endtask

    // Memory responder: random latency, one-cycle completion with a random line.
    initial begin
        forever begin
            @(negedge clk);
            if (mem_auto && (mem_read || mem_write)) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                pulse_resp(rand_line());
                end_resp();
            end
        end
    end

    always @(posedge clk) begin
        if (model_on && !rst) begin
            if (m_owner != 0) begin
                if (mem_resp) begin
                    m_last  = m_owner;
                    m_owner = 0;
                end
            end else begin
                logic ri, rd;
                ri = i_read | i_write;
                rd = d_read | d_write;
                if (ri && rd) m_owner = (m_last == 1) ? 2 : 1;
                else if (ri)  m_owner = 1;
                else if (rd)  m_owner = 2;
                if (m_owner == 1) begin
                    m_write = i_write; m_addr = i_address; m_wdata = i_wdata;
                end else if (m_owner == 2) begin
                    m_write = d_write; m_addr = d_address; m_wdata = d_wdata;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (model_on && !rst) begin
            check("rnd_mem_read",  mem_read,  (m_owner != 0) && !m_write);
            check("rnd_mem_write", mem_write, (m_owner != 0) && m_write);
            if (m_owner != 0) begin
                check("rnd_mem_addr", mem_address, m_addr);
                if (m_write) check("rnd_mem_wdata", mem_wdata, m_wdata);
            end
            if (mem_resp) begin
                check("rnd_i_resp", i_resp, m_owner == 1);
                check("rnd_d_resp", d_resp, m_owner == 2);
                check("rnd_i_rdata", i_rdata, (m_owner == 1) ? mem_rdata : '0);
                check("rnd_d_rdata", d_rdata, (m_owner == 2) ? mem_rdata : '0);
            end else begin
                check("rnd_no_resp", {i_resp, d_resp}, 2'b00);
            end
        end
    end

    initial begin
        logic [255:0] line;
        rst = 1'b1;
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        mem_resp = 1'b0;
        mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_rw", {mem_read, mem_write}, 2'b00);
        check("rst_mem_addr", mem_address, 0);
        check("rst_resp", {i_resp, d_resp}, 2'b00);
        check("rst_error", error, 0);
        rst = 1'b0;

        // I-only read with 3-cycle memory latency
        @(posedge clk); #1;
        set_req(0, 1'b1, 1'b0, 32'h0000_0100, '0);
        @(negedge clk);
        check("t2_not_yet", mem_read, 0);
        @(negedge clk);
        check("t2_mem_read", mem_read, 1);
        check("t2_mem_addr", mem_address, 32'h0000_0100);
        @(posedge clk);
        pulse_resp({32{8'hA5}});
        @(negedge clk);
        check("t2_i_resp", i_resp, 1);
        check("t2_i_rdata", i_rdata, {32{8'hA5}});
        check("t2_d_resp", d_resp, 0);
        check("t2_d_rdata", d_rdata, 0);
        end_resp();
        set_req(0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check("t2_idle", {mem_read, mem_write}, 2'b00);
        check("t2_error", error, 0);

        // Asynchronous reset in the middle of a transfer
        @(posedge clk); #1;
        set_req(0, 1'b1, 1'b0, 32'h0000_0200, '0);
        @(negedge clk);
        @(negedge clk);
        check("t1_pre_read", mem_read, 1);
        #2 rst = 1'b1;
        #1;
        check("t1_mem_read", mem_read, 0);
        check("t1_mem_addr", mem_address, 0);
        check("t1_error", error, 0);
        set_req(0, 1'b0, 1'b0, '0, '0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Simultaneous I read and D write after reset: D first, then I
        do_reset();
        line = rand_line();
        set_req(0, 1'b1, 1'b0, 32'h0000_0300, '0);
        set_req(1, 1'b0, 1'b1, 32'h0000_0400, line);
        @(negedge clk);
        @(negedge clk);
        check("t3_d_write", {mem_read, mem_write}, 2'b01);
        check("t3_d_addr", mem_address, 32'h0000_0400);
        check("t3_d_wdata", mem_wdata, line);
        pulse_resp('0);
        @(negedge clk);
        check("t3_d_resp", {i_resp, d_resp}, 2'b01);
        end_resp();
        set_req(1, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check("t3_gap", {mem_read, mem_write}, 2'b00);
        @(negedge clk);
        check("t3_i_read", {mem_read, mem_write}, 2'b10);
        check("t3_i_addr", mem_address, 32'h0000_0300);
        pulse_resp(line);
        @(negedge clk);
        check("t3_i_resp", {i_resp, d_resp}, 2'b10);
        check("t3_i_rdata", i_rdata, line);
        end_resp();
        set_req(0, 1'b0, 1'b0, '0, '0);

        // Both requesting continuously: D,I,D,I,D,I
        do_reset();
        set_req(0, 1'b1, 1'b0, 32'h0000_1000, '0);
        set_req(1, 1'b1, 1'b0, 32'h0000_2000, '0);
        for (int k = 0; k < 6; k++) begin
            serve_one($sformatf("t4_txn%0d", k), (k % 2 == 0) ? 32'h0000_2000 : 32'h0000_1000);
        end
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        check("t4_error", error, 0);

        // Stray mem_resp while idle
        do_reset();
        pulse_resp(rand_line());
        @(negedge clk);
        check("t5_no_resp", {i_resp, d_resp}, 2'b00);
        end_resp();
        @(negedge clk);
        check("t5_error_set", error, 1);
        repeat (3) @(negedge clk);
        check("t5_error_sticky", error, 1);
        do_reset();
        check("t5_error_clr", error, 0);

        // D read and write together: forwarded as write, error flagged
        set_req(1, 1'b1, 1'b1, 32'h0000_0040, '0);
        @(negedge clk);
        @(negedge clk);
        check("t6_rw", {mem_read, mem_write}, 2'b01);
        check("t6_addr", mem_address, 32'h0000_0040);
        check("t6_error", error, 1);
        pulse_resp('0);
        end_resp();
        set_req(1, 1'b0, 1'b0, '0, '0);

        // I drops its request while granted: transfer still completes, error flagged
        do_reset();
        line = rand_line();
        set_req(0, 1'b1, 1'b0, 32'h0000_0500, '0);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk); #1;
        set_req(0, 1'b0, 1'b0, 32'h0000_0500, '0);
        @(negedge clk);
        check("t7_still_read", mem_read, 1);
        pulse_resp(line);
        @(negedge clk);
        check("t7_i_resp", i_resp, 1);
        check("t7_i_rdata", i_rdata, line);
        check("t7_error", error, 1);
        end_resp();

        // Randomized traffic from both caches against the reference model
        do_reset();
        model_on = 1'b1;
        mem_auto = 1'b1;
        fork
            run_req(0, 20);
            run_req(1, 20);
        join
        repeat (5) @(posedge clk);
        #1;
        check("rnd_error", error, 0);
        model_on = 1'b0;
        mem_auto = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
